freq_generator: RTL and testbench

- Programmable square-wave source; the drive-side counterpart to the frequency meter.
- Takes a binary frequency setpoint in Hz and drives `pin_out` at that frequency with a 50 % duty cycle.
- Computes the half-period count from the setpoint with an on-block sequential divider.
- Used to stimulate the frequency meter's `pin_in` on the board and in loopback benches.

---
 rtl/freq_generator_if.sv | 23 ++
 rtl/freq_generator.sv | 143 ++++++++++++++
 tb/tb_freq_generator.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/freq_generator_if.sv
// Setpoint/control bundle for the square-wave generator.
// master drives freq_in/load/enable; slave returns pin_out/busy/running/err.
interface freq_generator_if #(
  parameter int FREQ_W = 20
);
  logic [FREQ_W-1:0] freq_in;
  logic              load;
  logic              enable;
  logic              pin_out;
  logic              busy;
  logic              running;
  logic              err;

  modport master (
    output freq_in, load, enable,
    input  pin_out, busy, running, err
  );

  modport slave (
    input  freq_in, load, enable,
    output pin_out, busy, running, err
  );
endinterface

// File: rtl/freq_generator.sv
// Programmable 50% square wave: setpoint in Hz -> half-period via divider.
// Ports: clk, rst (async active-low), bus (freq_in/load/enable in; pin_out/busy/running/err out).
module freq_generator #(
  parameter int CLK_HZ = 50000000,
  parameter int FREQ_W = 20,
  parameter int DIV_W  = 26
) (
  input logic        clk,
  input logic        rst,
  freq_generator_if.slave bus
);

  localparam int CW = $clog2(DIV_W + 1);
  localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(CLK_HZ);
  localparam logic [DIV_W-1:0] F_MAX = DIV_W'(CLK_HZ / 2);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DIV,
    RUN
  } state_t;

  state_t state, state_n;

  logic [FREQ_W-1:0] f_reg;
  logic [DIV_W:0]    rem, rem_n;
  logic [DIV_W:0]    divisor, diff;
  logic [DIV_W+1:0]  trial;
  logic [DIV_W-1:0]  quo, quo_n;
  logic [DIV_W-1:0]  half_q, cnt;
  logic [CW-1:0]     step;
  logic              bad, last, ge;
  logic              gated;
  logic              pin_q, busy_q;
  logic              run_q, err_q;

  assign bad = (f_reg == '0) ||
               (DIV_W'(f_reg) > F_MAX);
  assign last = (step == CW'(DIV_W - 1));
  assign divisor = (DIV_W+1)'({f_reg, 1'b0});

  // restoring divide step: shift in next dividend bit
  assign trial = {rem, quo[DIV_W-1]};
  assign ge = (trial >= {1'b0, divisor});
  assign diff = trial[DIV_W:0] - divisor;

  always_comb begin
    rem_n = trial[DIV_W:0];
    quo_n = {quo[DIV_W-2:0], 1'b0};
    if (ge) begin
      rem_n = diff;
      quo_n = {quo[DIV_W-2:0], 1'b1};
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (bus.load) state_n = CHECK;
      CHECK: state_n = bad ? IDLE : DIV;
      DIV:   if (last) state_n = RUN;
      RUN:   if (bus.load) state_n = CHECK;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_reg  <= '0;
      rem    <= '0;
      quo    <= '0;
      step   <= '0;
      half_q <= '0;
      cnt    <= '0;
      gated  <= 1'b0;
      pin_q  <= 1'b0;
      busy_q <= 1'b0;
      run_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.load) begin
            f_reg <= bus.freq_in;
            pin_q <= 1'b0;
          end
        end
        CHECK: begin
          err_q <= bad;
          rem   <= '0;
          quo   <= DIVIDEND;
          step  <= '0;
        end
        DIV: begin
          rem  <= rem_n;
          quo  <= quo_n;
          step <= step + CW'(1);
          if (last) begin
            half_q <= quo_n;
            cnt    <= '0;
            pin_q  <= bus.enable;
            // disabled at exit: first enable starts a full high phase
            gated  <= !bus.enable;
          end
        end
        RUN: begin
          if (bus.load) begin
            f_reg <= bus.freq_in;
            pin_q <= 1'b0;
            cnt   <= '0;
          end else if (!bus.enable) begin
            pin_q <= 1'b0;
            cnt   <= '0;
            gated <= 1'b1;
          end else if (gated) begin
            pin_q <= 1'b1;
            cnt   <= '0;
            gated <= 1'b0;
          end else if (cnt == half_q - DIV_W'(1)) begin
            pin_q <= !pin_q;
            cnt   <= '0;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
      endcase
      busy_q <= (state_n == CHECK) ||
                (state_n == DIV);
      run_q  <= (state_n == RUN);
    end
  end

  assign bus.pin_out = pin_q;
  assign bus.busy    = busy_q;
  assign bus.running = run_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_freq_generator.sv
// Scoreboard bench for freq_generator: loads queue expected results,
// a monitor checks them on every busy fall; waveform phases checked inline.
module tb_freq_generator;

  localparam int CLK_HZ = 50000000;
  localparam int FREQ_W = 25;
  localparam int DIV_W  = 26;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  freq_generator_if #(.FREQ_W(FREQ_W)) bus ();

  freq_generator #(
    .CLK_HZ(CLK_HZ),
    .FREQ_W(FREQ_W),
    .DIV_W (DIV_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic  err;
    int    half;
    int    blen;
    string name;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // monitor: a busy fall marks the end of one setpoint evaluation
  int   blen = 0;
  logic busy_d = 1'b0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      blen = 0;
      busy_d = 1'b0;
    end else begin
      if (bus.busy) begin
        blen++;
      end else if (busy_d) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got busy fall expected none");
        end else begin
          e = sb.pop_front();
          chk({e.name, "_err"}, bus.err, e.err);
          chk({e.name, "_running"}, bus.running, !e.err);
          chk({e.name, "_busy_len"}, blen, e.blen);
          if (!e.err)
            chk({e.name, "_half_q"}, dut.half_q, e.half);
        end
        blen = 0;
      end
      busy_d = bus.busy;
    end
  end

  task automatic do_load(input int f,
                         input bit e_err,
                         input int half,
                         input int bl,
                         input string nm,
                         input bit push);
    exp_t e;
    @(negedge clk);
    bus.freq_in = FREQ_W'(f);
    bus.load = 1'b1;
    if (push) begin
      e.err = e_err;
      e.half = half;
      e.blen = bl;
      e.name = nm;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.busy) begin
      errors++;
      $display("FAIL %s_timeout: got busy=1 expected 0", nm);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_level(input logic lvl,
                             input int bound,
                             output int n);
    n = 0;
    while (bus.pin_out == lvl && n < bound) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_pin"}, bus.pin_out, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_running"}, bus.running, 0);
    chk({nm, "_err"}, bus.err, 0);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    logic e;
    bus.freq_in = '0;
    bus.load = 1'b0;
    bus.enable = 1'b1;
    #2 rst = 1'b0;
    cycles(3);
    chk_zero("reset");
    chk("reset_half_q", dut.half_q, 0);
    rst = 1'b1;
    cycles(2);

    // 1000 Hz, enable gating mid-high
    do_load(1000, 0, 25000, 27, "f1000", 1);
    wait_idle("f1000");
    chk("f1000_pin_exit", bus.pin_out, 1);
    cycles(100);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("en_off_pin", bus.pin_out, 0);
    chk("en_off_running", bus.running, 1);
    cycles(5);
    bus.enable = 1'b1;
    @(negedge clk);
    chk("en_on_pin", bus.pin_out, 1);
    count_level(1'b1, 25100, n);
    chk("f1000_high", n, 25000);
    count_level(1'b0, 25100, n);
    chk("f1000_low", n, 25000);

    // retune mid-high, second load during DIV ignored
    cycles(10);
    do_load(10000, 0, 2500, 27, "f10k", 1);
    chk("retune_pin", bus.pin_out, 0);
    chk("retune_busy", bus.busy, 1);
    cycles(5);
    do_load(300, 0, 0, 0, "ignored", 0);
    wait_idle("f10k");
    count_level(1'b1, 2600, n);
    chk("f10k_high", n, 2500);
    count_level(1'b0, 2600, n);
    chk("f10k_low", n, 2500);

    // fastest setting toggles every clock
    do_load(25000000, 0, 1, 27, "fmax", 1);
    wait_idle("fmax");
    for (int i = 0; i < 6; i++) begin
      e = (i % 2 == 0);
      chk("fmax_toggle", bus.pin_out, e);
      @(negedge clk);
    end
    do_load(300, 0, 83333, 27, "f300", 1);
    wait_idle("f300");
    chk("f300_pin", bus.pin_out, 1);

    // out-of-range setpoints
    do_load(0, 1, 0, 1, "fzero", 1);
    wait_idle("fzero");
    chk("fzero_pin", bus.pin_out, 0);
    cycles(5);
    chk("fzero_err_sticky", bus.err, 1);
    do_load(25000001, 1, 0, 1, "fover", 1);
    wait_idle("fover");
    chk("fover_pin", bus.pin_out, 0);
    do_load(500, 0, 50000, 27, "f500", 1);
    wait_idle("f500");

    // reset mid-DIV
    do_load(1000, 0, 25000, 27, "rst_div", 1);
    cycles(8);
    #2 rst = 1'b0;
    #1;
    chk_zero("rst_div");
    chk("rst_div_half_q", dut.half_q, 0);
    sb.delete();
    cycles(2);
    rst = 1'b1;
    cycles(50);
    chk_zero("post_rst_div");

    // reset mid-RUN
    do_load(10000, 0, 2500, 27, "f10k_b", 1);
    wait_idle("f10k_b");
    cycles(100);
    #2 rst = 1'b0;
    #1;
    chk_zero("rst_run");
    chk("rst_run_half_q", dut.half_q, 0);
    cycles(2);
    rst = 1'b1;
    cycles(20);
    chk_zero("post_rst_run");

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
